// File: rtl/gf_array_feeder.sv
// Operand feeder for the GF(2^M) systolic multiplier: buffers (a, b) pairs and
// issues each as a PERIOD-cycle frame (one load cycle, then hold cycles).
module gf_array_feeder #(
   parameter int M      = 16,
   parameter int PERIOD = 16,
   parameter int DEPTH  = 2
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [M-1:0] i_g_in,
   input  logic         i_g_we,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [M-1:0] i_a_in,
   input  logic [M-1:0] i_b_in,
   output logic [M-1:0] o_ai,
   output logic [M-1:0] o_gi,
   output logic [M-1:0] o_bi,
   output logic         o_ctr,
   output logic         o_pi,
   output logic [M-2:0] o_pih,
   output logic [M-2:0] o_piv,
   output logic         o_busy,
   output logic [7:0]   o_issued
);

   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int CNW = $clog2(PERIOD + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

   state_t          r_state, w_next;
   logic [M-1:0]    r_mem_a [DEPTH];
   logic [M-1:0]    r_mem_b [DEPTH];
   logic [PW-1:0]   r_wp, r_rp;
   logic [CW-1:0]   r_count, w_count_next;
   logic            r_ready;
   logic [CNW-1:0]  r_cnt;
   logic [M-1:0]    r_g, r_ai, r_bi;
   logic            r_ctr;
   logic [7:0]      r_issued;
   logic            w_push, w_pop, w_empty;

   assign w_empty      = (r_count == '0);
   assign w_push       = i_in_valid & r_ready;
   assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      case (r_state)
         S_IDLE: if (!w_empty) w_next = S_LOAD;
         // the head stays in the FIFO until the load cycle itself retires it
         S_LOAD: begin
            w_pop  = 1'b1;
            w_next = S_HOLD;
         end
         S_HOLD: if (r_cnt == CNW'(PERIOD - 1)) w_next = w_empty ? S_IDLE : S_LOAD;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem_a[r_wp] <= i_a_in;
         r_mem_b[r_wp] <= i_b_in;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wp     <= '0;
         r_rp     <= '0;
         r_count  <= '0;
         r_ready  <= 1'b0;
         r_g      <= '0;
         r_ai     <= '0;
         r_bi     <= '0;
         r_ctr    <= 1'b0;
         r_cnt    <= '0;
         r_issued <= '0;
      end else begin
         if (w_push) r_wp <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
         if (w_pop)  r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
         r_count <= w_count_next;
         r_ready <= (w_count_next != CW'(DEPTH));

         // a first operand arriving now makes the buffer non-empty, so g is frozen
         if (i_g_we && r_state == S_IDLE && w_empty && !w_push) r_g <= i_g_in;

         case (r_state)
            S_LOAD:  r_cnt <= CNW'(1);
            S_HOLD:  r_cnt <= r_cnt + 1'b1;
            default: r_cnt <= '0;
         endcase

         case (w_next)
            S_LOAD: begin
               r_ai     <= r_mem_a[r_rp];
               r_bi     <= r_mem_b[r_rp];
               r_ctr    <= 1'b0;
               r_issued <= r_issued + 8'd1;
            end
            S_HOLD: begin
               r_bi  <= '0;
               r_ctr <= 1'b1;
            end
            default: begin
               r_ai  <= '0;
               r_bi  <= '0;
               r_ctr <= 1'b0;
            end
         endcase
      end
   end

   assign o_in_ready = r_ready;
   assign o_ai       = r_ai;
   assign o_bi       = r_bi;
   assign o_gi       = r_g;
   assign o_ctr      = r_ctr;
   assign o_pi       = 1'b0;
   assign o_pih      = '0;
   assign o_piv      = '0;
   assign o_busy     = (r_state != S_IDLE) | !w_empty;
   assign o_issued   = r_issued;

endmodule

// File: tb/tb_gf_array_feeder.sv
// Directed bench for gf_array_feeder: framing, handshake, g register, reset, wrap.
module tb_gf_array_feeder;

   localparam int M      = 16;
   localparam int PERIOD = 16;
   localparam int DEPTH  = 2;

   logic         clk = 1'b0;
   logic         rst, g_we, in_valid, in_ready, ctr, pi, busy;
   logic [M-1:0] g_in, a_in, b_in, ai, gi, bi;
   logic [M-2:0] pih, piv;
   logic [7:0]   issued;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   gf_array_feeder #(.M(M), .PERIOD(PERIOD), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst), .i_g_in(g_in), .i_g_we(g_we),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_a_in(a_in), .i_b_in(b_in),
      .o_ai(ai), .o_gi(gi), .o_bi(bi), .o_ctr(ctr), .o_pi(pi), .o_pih(pih),
      .o_piv(piv), .o_busy(busy), .o_issued(issued)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ai"}, ai, 0);
      chk({tag, "_bi"}, bi, 0);
      chk({tag, "_ctr"}, ctr, 0);
      chk({tag, "_pi"}, pi, 0);
      chk({tag, "_pih"}, pih, 0);
      chk({tag, "_piv"}, piv, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int pushed, loads, last_load, cyc;
      logic acc;
      logic [7:0] prev_iss;
      logic [15:0] av;

      rst = 1'b1; g_we = 1'b0; g_in = '0; in_valid = 1'b0; a_in = '0; b_in = '0;

      // reset, then idle
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_ready", in_ready, 1);
         chk("idle_busy", busy, 0);
      end
      chk_idle("rst");
      chk("rst_gi", gi, 0);
      chk("rst_issued", issued, 0);

      // single op
      g_in = 16'h002B; g_we = 1'b1;
      tick();
      g_we = 1'b0;
      chk("g_load", gi, 16'h002B);
      a_in = 16'h1234; b_in = 16'hABCD; in_valid = 1'b1;
      tick();                                   // t+1
      in_valid = 1'b0;
      chk("t1_busy", busy, 1);
      chk("t1_ctr", ctr, 0);
      chk("t1_ai", ai, 0);
      tick();                                   // t+2
      chk("load_ctr", ctr, 0);
      chk("load_ai", ai, 16'h1234);
      chk("load_bi", bi, 16'hABCD);
      chk("load_gi", gi, 16'h002B);
      chk("load_issued", issued, 1);
      for (int k = 3; k <= 17; k++) begin
         if (k == 5) begin g_in = 16'hFFFF; g_we = 1'b1; end
         if (k == 6) g_we = 1'b0;
         tick();
         chk("hold_ctr", ctr, 1);
         chk("hold_ai", ai, 16'h1234);
         chk("hold_bi", bi, 0);
         chk("hold_gi", gi, 16'h002B);
      end
      g_we = 1'b0;
      tick();                                   // t+18
      chk_idle("end1");
      chk("end1_issued", issued, 1);
      chk("end1_gi", gi, 16'h002B);
      g_in = 16'hFFFF; g_we = 1'b1;
      tick();
      chk("g_idle_load", gi, 16'hFFFF);
      g_in = 16'h002B;
      tick();
      g_we = 1'b0;
      chk("g_restore", gi, 16'h002B);

      // back-to-back, third push stalls; g_we with first push is ignored
      chk("b2b_ready0", in_ready, 1);
      in_valid = 1'b1; a_in = 16'h1111; b_in = 16'h2222;
      g_we = 1'b1; g_in = 16'h5A5A;
      tick();                                   // c=1
      g_we = 1'b0;
      chk("b2b_g_ignored", gi, 16'h002B);
      chk("b2b_ready1", in_ready, 1);
      a_in = 16'h0000; b_in = 16'h5555;
      tick();                                   // c=2
      chk("b2b_ready2", in_ready, 0);
      chk("b2b_l0_ctr", ctr, 0);
      chk("b2b_l0_ai", ai, 16'h1111);
      chk("b2b_l0_bi", bi, 16'h2222);
      chk("b2b_l0_iss", issued, 2);
      a_in = 16'hABCD; b_in = 16'h0000;
      tick();                                   // c=3
      chk("b2b_ready3", in_ready, 1);
      tick();                                   // c=4
      in_valid = 1'b0;
      chk("b2b_ready4", in_ready, 0);
      for (int c = 5; c <= 50; c++) begin
         tick();
         if (c == 17 || c == 33) chk("b2b_hold_end", ctr, 1);
         if (c == 18) begin
            chk("b2b_l1_ctr", ctr, 0);
            chk("b2b_l1_ai", ai, 16'h0000);
            chk("b2b_l1_bi", bi, 16'h5555);
            chk("b2b_l1_iss", issued, 3);
            chk("b2b_l1_busy", busy, 1);
         end
         if (c == 34) begin
            chk("b2b_l2_ctr", ctr, 0);
            chk("b2b_l2_ai", ai, 16'hABCD);
            chk("b2b_l2_bi", bi, 16'h0000);
            chk("b2b_l2_iss", issued, 4);
         end
         if (c == 49) chk("b2b_last_hold", ctr, 1);
      end
      chk_idle("b2b_end");
      chk("b2b_end_iss", issued, 4);

      // reset mid-frame with one op buffered
      in_valid = 1'b1; a_in = 16'h7777; b_in = 16'h8888;
      tick();                                   // c=1
      in_valid = 1'b0;
      tick();                                   // c=2
      chk("mid_load_ai", ai, 16'h7777);
      in_valid = 1'b1; a_in = 16'h9999; b_in = 16'h1357;
      tick();                                   // c=3
      in_valid = 1'b0;
      tick(); tick(); tick();                   // c=6
      chk("mid_hold_ctr", ctr, 1);
      tick();                                   // c=7, 5th hold cycle
      rst = 1'b1;
      tick();
      chk_idle("mid_rst");
      chk("mid_rst_gi", gi, 0);
      chk("mid_rst_iss", issued, 0);
      chk("mid_rst_ready", in_ready, 0);
      rst = 1'b0;
      tick();
      chk("mid_ready", in_ready, 1);
      for (int i = 0; i < 20; i++) tick();
      chk_idle("mid_after");
      chk("mid_after_iss", issued, 0);

      // 256 back-to-back operations: issued wraps, spacing held at PERIOD
      pushed = 0; loads = 0; last_load = 0; cyc = 0; prev_iss = issued;
      while (loads < 256 && cyc < 6000) begin
         if (pushed < 256) begin
            av = pushed[15:0];
            in_valid = 1'b1; a_in = av; b_in = 16'hFFFF ^ av;
         end else begin
            in_valid = 1'b0;
         end
         acc = in_valid & in_ready;
         tick();
         cyc++;
         if (acc) pushed++;
         if (issued != prev_iss) begin
            chk("wrap_ai", ai, loads);
            chk("wrap_ctr", ctr, 0);
            if (loads > 0) chk("wrap_gap", cyc - last_load, PERIOD);
            last_load = cyc;
            loads++;
            prev_iss = issued;
         end
      end
      in_valid = 1'b0;
      chk("wrap_loads", loads, 256);
      chk("wrap_issued", issued, 0);
      for (int i = 0; i < 40 && busy; i++) tick();
      chk("wrap_done_busy", busy, 0);
      chk("wrap_done_iss", issued, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
